// File: rtl/ifetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_ctrl_pkg
//  Brief    : Shared types and constants for the instruction-fetch controller
//  Revision : 1.0  initial release
// ============================================================================
package ifetch_ctrl_pkg;

   // Fetch FSM encoding
   typedef enum logic [1:0] {
      S_REQ   = 2'd0,   // free to issue a request
      S_WAIT  = 2'd1,   // one request outstanding, response is wanted
      S_DRAIN = 2'd2    // one request outstanding, response belongs to a flushed path
   } state_t;

   // Bytes per instruction; sequential fetch advances the PC by this amount
   localparam int INSTR_BYTES = 4;

   // Default reset vector
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : ifetch_ctrl_pkg
`default_nettype wire

// File: rtl/ifetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_ctrl_if
//  Brief    : PC, instruction-memory, redirect and decode-side signals of the
//             fetch controller, with master (controller) / slave (environment)
//  Revision : 1.0  initial release
// ============================================================================
interface ifetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // PC register side
   logic [ADDR_W-1:0] pc_in;
   logic [ADDR_W-1:0] pc_next;
   logic              pc_en_n;
   // Instruction memory side
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   // Redirect from execute
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   // Decode side
   logic              id_valid;
   logic [DATA_W-1:0] id_instr;
   logic [ADDR_W-1:0] id_pc;
   logic              id_ready;

   modport master (
      input  pc_in,
      output pc_next, pc_en_n,
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      input  redirect, redirect_pc,
      output id_valid, id_instr, id_pc,
      input  id_ready
   );

   modport slave (
      output pc_in,
      input  pc_next, pc_en_n,
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      output redirect, redirect_pc,
      input  id_valid, id_instr, id_pc,
      output id_ready
   );

endinterface : ifetch_ctrl_if
`default_nettype wire

// File: rtl/ifetch_ctrl_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_ctrl_fetch_fifo
//  Brief    : Small FIFO holding fetched {pc, instr} pairs for decode, with
//             synchronous flush and registered head
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_ctrl_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             i_flush,
   input  wire logic             i_push,
   input  wire logic [WIDTH-1:0] i_data,
   input  wire logic             i_pop,
   output      logic             o_valid,
   output      logic [WIDTH-1:0] o_data,
   output      logic             o_full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_do_push;
   logic             w_do_pop;

   // A flush overrides both push and pop in the same cycle
   assign w_do_pop  = i_pop && (r_count != '0) && !i_flush;
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_data  = r_mem[r_rd_ptr];

   // Pointer and occupancy bookkeeping; flush empties the queue
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
      end
   end

   // Storage array; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule : ifetch_ctrl_fetch_fifo
`default_nettype wire

// File: rtl/ifetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ifetch_ctrl
//  Brief    : Single-outstanding instruction-fetch controller: issues memory
//             reads at the current PC, drives the next-PC mux and active-low
//             PC enable, and queues returned instructions for decode
//  Revision : 1.0  initial release
// ============================================================================
module ifetch_ctrl
   import ifetch_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input wire logic     clk,
   input wire logic     rst,
   ifetch_ctrl_if.master bus
);
   state_t              r_state;
   logic [ADDR_W-1:0]   r_req_pc;

   logic                w_full;
   logic                w_id_valid;
   logic                w_imem_req;
   logic                w_grant;
   logic                w_push;
   logic                w_pop;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [ADDR_W-1:0]   w_pc_next;
   logic                w_pc_en_n;
   logic [ADDR_W+DATA_W-1:0] w_head;

   // A request needs a free slot; with nothing outstanding in S_REQ the slot is guaranteed
   assign w_imem_req = (r_state == S_REQ) && !w_full && !bus.redirect && !rst;
   assign w_grant    = w_imem_req && bus.imem_gnt;
   assign w_pc_inc   = bus.pc_in + ADDR_W'(INSTR_BYTES);

   // A response coinciding with a redirect belongs to the old path and is dropped
   assign w_push     = (r_state == S_WAIT) && bus.imem_rvalid && !bus.redirect;
   assign w_pop      = w_id_valid && bus.id_ready;

   // Next-PC mux: reset vector, then redirect, then sequential advance on grant
   always_comb begin
      w_pc_next = w_pc_inc;
      w_pc_en_n = 1'b1;
      if (rst) begin
         w_pc_next = RESET_PC;
         w_pc_en_n = 1'b0;
      end else if (bus.redirect) begin
         w_pc_next = bus.redirect_pc;
         w_pc_en_n = 1'b0;
      end else if (w_grant) begin
         w_pc_next = w_pc_inc;
         w_pc_en_n = 1'b0;
      end
   end

   // Fetch FSM: track the single outstanding request and whether its data is still wanted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_REQ;
         r_req_pc <= '0;
      end else begin
         case (r_state)
            S_REQ: begin
               if (w_grant) begin
                  r_state  <= S_WAIT;
                  r_req_pc <= bus.pc_in;
               end
            end
            S_WAIT: begin
               if (bus.imem_rvalid)   r_state <= S_REQ;
               else if (bus.redirect) r_state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (bus.imem_rvalid) r_state <= S_REQ;
            end
            default: r_state <= S_REQ;
         endcase
      end
   end

   ifetch_ctrl_fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (bus.redirect),
      .i_push  (w_push),
      .i_data  ({r_req_pc, bus.imem_rdata}),
      .i_pop   (w_pop),
      .o_valid (w_id_valid),
      .o_data  (w_head),
      .o_full  (w_full)
   );

   assign bus.imem_req  = w_imem_req;
   assign bus.imem_addr = bus.pc_in;
   assign bus.pc_next   = w_pc_next;
   assign bus.pc_en_n   = w_pc_en_n;
   assign bus.id_valid  = w_id_valid;
   assign bus.id_pc     = w_head[DATA_W +: ADDR_W];
   assign bus.id_instr  = w_head[DATA_W-1:0];

endmodule : ifetch_ctrl
`default_nettype wire
